// File: rtl/phase_gen.sv
// Two-phase non-overlapping CPU clock generator: divides ph0 by DIV into ph1/ph2 with GAP dead clocks.
// Optional stretch input enabled by the PHASE_GEN_HALT_EN macro.
`timescale 1ns/1ps
module phase_gen #(
  parameter int DIV   = 12,
  parameter int GAP   = 1,
  parameter int CYC_W = 16
) (
  input  logic             ph0,
  input  logic             res_n,
`ifdef PHASE_GEN_HALT_EN
  input  logic             halt,
`endif
  output logic             ph1,
  output logic             ph2,
  output logic             ph1_out,
  output logic             ph2_out,
  output logic             ph1_start,
  output logic             ph2_start,
  output logic             cycle_end,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] C_GAP      = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] C_HALF_GAP = CNT_W'(HALF + GAP);
  localparam logic [CNT_W-1:0] C_HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(DIV - 1);

  if ((DIV % 2) != 0 || DIV < 4 || GAP < 0 || GAP > HALF - 1) begin : g_param_err
    $error("phase_gen: DIV must be even and >= 4, and 0 <= GAP <= DIV/2-1");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_run;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_hold;
  logic             w_wrap;
  logic             w_ph1_nxt;
  logic             w_ph2_nxt;
  logic             w_ph1_start_nxt;
  logic             w_ph2_start_nxt;
  logic             w_cycle_end_nxt;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v < hi);
  endfunction

  // Outputs are registered from the decode of the counter value entering the next period.
  always_comb begin
    w_hold = 1'b0;
`ifdef PHASE_GEN_HALT_EN
    w_hold = halt && r_run && (r_cnt == C_HALF_M1);
`endif
    w_wrap = r_run && !w_hold && (r_cnt == C_LAST);
    if (!r_run) begin
      w_cnt_nxt = '0;
    end else if (w_hold) begin
      w_cnt_nxt = r_cnt;
    end else if (w_wrap) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    w_ph1_nxt       = in_range(int'(w_cnt_nxt), GAP, HALF);
    w_ph2_nxt       = in_range(int'(w_cnt_nxt), HALF + GAP, DIV);
    w_ph1_start_nxt = !w_hold && (w_cnt_nxt == C_GAP);
    w_ph2_start_nxt = !w_hold && (w_cnt_nxt == C_HALF_GAP);
    w_cycle_end_nxt = !w_hold && (w_cnt_nxt == C_LAST);
  end

  always_ff @(posedge ph0) begin
    if (!res_n) begin
      r_cnt       <= '0;
      r_run       <= 1'b0;
      ph1         <= 1'b0;
      ph2         <= 1'b0;
      ph1_out     <= 1'b0;
      ph2_out     <= 1'b0;
      ph1_start   <= 1'b0;
      ph2_start   <= 1'b0;
      cycle_end   <= 1'b0;
      cycle_count <= '0;
    end else begin
      r_run     <= 1'b1;
      r_cnt     <= w_cnt_nxt;
      ph1       <= w_ph1_nxt;
      ph2       <= w_ph2_nxt;
      ph1_out   <= w_ph1_nxt;
      ph2_out   <= w_ph2_nxt;
      ph1_start <= w_ph1_start_nxt;
      ph2_start <= w_ph2_start_nxt;
      cycle_end <= w_cycle_end_nxt;
      if (w_wrap) begin
        cycle_count <= cycle_count + CYC_W'(1);
      end
    end
  end

endmodule
